input_buffer_sched: RTL and testbench

INPUT_BUFFER_SCHED -- requirements
Module: input_buffer_sched

---
 rtl/input_buffer_sched_if.sv | 29 ++
 rtl/input_buffer_sched.sv | 161 ++++++++++++++++
 tb/tb_input_buffer_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_buffer_sched_if.sv
// Requester-side and transpose-side handshake bundle for input_buffer_sched.
// slave is the scheduler's view, master is the requesters / transpose unit view.
interface input_buffer_sched_if #(
    parameter int NUM_PORTS = 4,
    parameter int CW        = 7
);
    logic [NUM_PORTS-1:0]   port_req_i;
    logic [8*NUM_PORTS-1:0] port_data_i;
    logic [NUM_PORTS-1:0]   port_vld_i;
    logic [NUM_PORTS-1:0]   port_rdy_o;
    logic [NUM_PORTS-1:0]   port_gnt_o;
    logic [7:0]             trans_data_o;
    logic                   trans_vld_o;
    logic [CW-1:0]          trans_channel_num_o;
    logic                   trans_new_packet_o;
    logic                   trans_packet_received_i;

    modport slave (
        input  port_req_i, port_data_i, port_vld_i, trans_packet_received_i,
        output port_rdy_o, port_gnt_o, trans_data_o, trans_vld_o,
               trans_channel_num_o, trans_new_packet_o
    );

    modport master (
        output port_req_i, port_data_i, port_vld_i, trans_packet_received_i,
        input  port_rdy_o, port_gnt_o, trans_data_o, trans_vld_o,
               trans_channel_num_o, trans_new_packet_o
    );
endinterface

// File: rtl/input_buffer_sched.sv
// Round-robin scheduler moving whole word-serial packets from NUM_PORTS requesters
// into a transpose unit, with a token count of packets buffered downstream.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no packet in flight; grant the RR winner if tokens not full
// S_LOAD    | granted port streams cfg+1 words to the transpose unit
// S_DRAIN   | all words delivered; wait for transpose readout to finish
// S_RELEASE | one-cycle new-packet pulse, grant dropped, back to idle
module input_buffer_sched #(
    parameter  int NUM_PORTS       = 4,
    parameter  int MAX_CHANNEL_NUM = 128,
    parameter  int TOKEN_W         = 4,
    localparam int CW              = $clog2(MAX_CHANNEL_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input_buffer_sched_if.slave  bus,
    input  logic [CW-1:0]        cfg_channel_num_i,
    input  logic                 token_dec_i,
    output logic [TOKEN_W-1:0]   token_cnt_o,
    output logic                 token_full_o,
    output logic                 busy_o
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_DRAIN   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PW-1:0]        r_rr_ptr;
    logic [NUM_PORTS-1:0] r_gnt;
    logic [CW-1:0]        r_chan;
    logic [CW-1:0]        r_wcnt;
    logic [TOKEN_W-1:0]   r_tok;

    logic [PW-1:0]        w_win_idx;
    logic                 w_win_found;
    logic [NUM_PORTS-1:0] w_win_oh;
    logic [7:0]           w_sel_data;
    logic                 w_sel_vld;
    logic                 w_grant;
    logic                 w_accept;
    logic                 w_tok_inc;

    // r_rr_ptr is the first port searched, i.e. the one after the last grant.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!w_win_found && bus.port_req_i[p] &&
                    (p == (int'(r_rr_ptr) + i) % NUM_PORTS)) begin
                    w_win_found = 1'b1;
                    w_win_idx   = PW'(p);
                end
            end
        end
    end

    assign w_win_oh = NUM_PORTS'(1) << w_win_idx;

    always_comb begin
        w_sel_data = '0;
        w_sel_vld  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_gnt[p]) begin
                w_sel_data = bus.port_data_i[8*p +: 8];
                w_sel_vld  = bus.port_vld_i[p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt                = r_state;
        w_grant                    = 1'b0;
        w_accept                   = 1'b0;
        w_tok_inc                  = 1'b0;
        bus.port_rdy_o             = '0;
        bus.trans_vld_o            = 1'b0;
        bus.trans_data_o           = 8'h00;
        bus.trans_new_packet_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_found && !token_full_o) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.port_rdy_o  = r_gnt;
                bus.trans_vld_o = w_sel_vld;
                bus.trans_data_o = w_sel_data;
                w_accept        = w_sel_vld;
                if (w_sel_vld && (r_wcnt == r_chan)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.trans_packet_received_i) begin
                    w_tok_inc   = 1'b1;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                bus.trans_new_packet_o = 1'b1;
                w_state_nxt            = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_chan   <= '0;
            r_wcnt   <= '0;
            r_tok    <= '0;
        end else begin
            if (w_grant) begin
                r_gnt    <= w_win_oh;
                r_chan   <= cfg_channel_num_i;
                r_wcnt   <= '0;
                r_rr_ptr <= (w_win_idx == PW'(NUM_PORTS - 1)) ? '0 : w_win_idx + 1'b1;
            end
            if (w_accept) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (r_state == S_RELEASE) begin
                r_gnt <= '0;
            end
            // A simultaneous increment and decrement cancel; decrement at zero is dropped.
            if (w_tok_inc && !token_dec_i) begin
                r_tok <= r_tok + 1'b1;
            end else if (!w_tok_inc && token_dec_i && (r_tok != '0)) begin
                r_tok <= r_tok - 1'b1;
            end
        end
    end

    assign bus.port_gnt_o          = r_gnt;
    assign bus.trans_channel_num_o = r_chan;
    assign token_cnt_o             = r_tok;
    assign token_full_o            = &r_tok;
    assign busy_o                  = (r_state != S_IDLE);

endmodule

// File: tb/tb_input_buffer_sched.sv
// Scoreboard bench for input_buffer_sched: packets are ordered by a queue-level
// round-robin model, expected words are queued, and a negedge monitor checks them.
module tb_input_buffer_sched;
    localparam int NP    = 4;
    localparam int MAXC  = 128;
    localparam int TW    = 2;
    localparam int CW    = $clog2(MAXC);
    localparam int TFULL = (1 << TW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [CW-1:0] cfg;
    logic          dec_rand = 1'b0;
    logic          dec_drv = 1'b0;
    logic          dec_rand_en = 1'b0;
    logic          dec_on_recv = 1'b0;
    logic          token_dec;
    logic [TW-1:0] token_cnt;
    logic          token_full;
    logic          busy;

    assign token_dec = dec_rand | dec_drv;

    input_buffer_sched_if #(.NUM_PORTS(NP), .CW(CW)) bus ();

    input_buffer_sched #(
        .NUM_PORTS      (NP),
        .MAX_CHANNEL_NUM(MAXC),
        .TOKEN_W        (TW)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .bus              (bus),
        .cfg_channel_num_i(cfg),
        .token_dec_i      (token_dec),
        .token_cnt_o      (token_cnt),
        .token_full_o     (token_full),
        .busy_o           (busy)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int model_ptr = 0;
    int m_tok = 0;

    logic [7:0]    sb_data[$];
    logic [NP-1:0] sb_gnt[$];
    logic [CW-1:0] sb_chan[$];
    logic [7:0]    wq[NP][$];
    int            lq[NP][$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_zero_outs(string name);
        check(name, {bus.port_gnt_o, bus.port_rdy_o, bus.trans_data_o, bus.trans_vld_o,
                     bus.trans_channel_num_o, bus.trans_new_packet_o, token_cnt,
                     token_full, busy}, 64'd0);
    endfunction

    // Token reference: packets finished minus packets consumed, never below zero.
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_tok <= 0;
        end else if (bus.trans_packet_received_i && !token_dec) begin
            m_tok <= m_tok + 1;
        end else if (!bus.trans_packet_received_i && token_dec && m_tok > 0) begin
            m_tok <= m_tok - 1;
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if ((bus.port_vld_i & bus.port_rdy_o) != '0) begin
                check("fwd_vld", {63'd0, bus.trans_vld_o}, 64'd1);
                if (sb_data.size() == 0) begin
                    check("sb_extra_word", 64'd1, 64'd0);
                end else begin
                    check("fwd_data", {56'd0, bus.trans_data_o}, {56'd0, sb_data.pop_front()});
                    check("fwd_gnt", {60'd0, bus.port_gnt_o}, {60'd0, sb_gnt.pop_front()});
                    check("fwd_chan", {57'd0, bus.trans_channel_num_o}, {57'd0, sb_chan.pop_front()});
                end
            end
            if (!busy) begin
                check("idle_outs", {bus.port_rdy_o, bus.trans_vld_o, bus.trans_data_o,
                                    bus.port_gnt_o, bus.trans_new_packet_o}, 64'd0);
            end
            check("token_cnt", {62'd0, token_cnt}, 64'(m_tok));
            check("token_full", {63'd0, token_full}, {63'd0, (m_tok == TFULL)});
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            dec_rand = dec_rand_en && ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.port_req_i              = '0;
        bus.port_vld_i              = '0;
        bus.port_data_i             = '0;
        bus.trans_packet_received_i = 1'b0;
        dec_drv                     = 1'b0;
        cfg                         = '0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        clear_inputs();
        #2;
        check_zero_outs("rst_outs");
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i   = 1'b1;
        model_ptr = 0;
    endtask

    task automatic add_pkt(int p, int len);
        lq[p].push_back(len);
        for (int k = 0; k < len; k++) wq[p].push_back(8'($urandom));
    endtask

    task automatic run_packets();
        int            ord_p[$];
        int            ord_len[$];
        logic [7:0]    drv_w[$];
        int            pend[NP];
        int            rem, pick, len, cyc, idx, g;
        logic          acc;
        logic [7:0]    w;
        rem = 0;
        for (int p = 0; p < NP; p++) begin
            pend[p] = lq[p].size();
            rem += pend[p];
        end
        // Reference order: next port after the last winner that still holds a packet.
        while (rem > 0) begin
            pick = -1;
            for (int i = 0; i < NP && pick < 0; i++) begin
                if (lq[(model_ptr + i) % NP].size() > 0) pick = (model_ptr + i) % NP;
            end
            model_ptr = (pick + 1) % NP;
            len = lq[pick].pop_front();
            ord_p.push_back(pick);
            ord_len.push_back(len);
            for (int k = 0; k < len; k++) begin
                w = wq[pick].pop_front();
                sb_data.push_back(w);
                sb_gnt.push_back(NP'(1) << pick);
                sb_chan.push_back(CW'(len - 1));
                drv_w.push_back(w);
            end
            rem--;
        end
        for (int k = 0; k < ord_p.size(); k++) begin
            g   = ord_p[k];
            len = ord_len[k];
            cfg = CW'(len - 1);
            for (int p = 0; p < NP; p++) bus.port_req_i[p] = (pend[p] > 0);
            cyc = 0;
            while (bus.port_gnt_o == '0 && cyc < 300) begin
                @(posedge clk_i);
                #1;
                cyc++;
            end
            if (bus.port_gnt_o == '0) begin
                check("grant_timeout", 64'd0, 64'd1);
                return;
            end
            pend[g]--;
            bus.port_req_i[g] = (pend[g] > 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cfg = CW'($urandom);
            idx = 0;
            cyc = 0;
            while (idx < len && cyc < 300) begin
                for (int p = 0; p < NP; p++) begin
                    bus.port_vld_i[p]        = 1'($urandom_range(0, 1));
                    bus.port_data_i[8*p +: 8] = 8'($urandom);
                end
                bus.port_vld_i[g]         = ($urandom_range(0, 2) != 0);
                bus.port_data_i[8*g +: 8] = drv_w[0];
                acc = bus.port_vld_i[g] & bus.port_rdy_o[g];
                @(posedge clk_i);
                #1;
                cyc++;
                if (acc) begin
                    void'(drv_w.pop_front());
                    idx++;
                end
            end
            bus.port_vld_i    = '0;
            bus.port_data_i   = '0;
            bus.port_req_i[g] = (pend[g] > 0);
            if (idx < len) begin
                check("load_timeout", 64'(idx), 64'(len));
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                check("drain_quiet", {59'd0, bus.port_rdy_o, bus.trans_vld_o}, 64'd0);
                @(posedge clk_i);
                #1;
            end
            check("drain_quiet", {59'd0, bus.port_rdy_o, bus.trans_vld_o}, 64'd0);
            bus.trans_packet_received_i = 1'b1;
            dec_drv = dec_on_recv;
            @(posedge clk_i);
            #1;
            bus.trans_packet_received_i = 1'b0;
            dec_drv = 1'b0;
            check("new_pkt_pulse", {63'd0, bus.trans_new_packet_o}, 64'd1);
            @(posedge clk_i);
            #1;
            check("new_pkt_single", {63'd0, bus.trans_new_packet_o}, 64'd0);
            check("busy_after_release", {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        int cyc;
        clear_inputs();
        do_reset();

        // Single packet, port 1, known words.
        cfg = 3;
        lq[1].push_back(4);
        wq[1].push_back(8'h11); wq[1].push_back(8'h22);
        wq[1].push_back(8'h33); wq[1].push_back(8'h44);
        run_packets();
        check("t1_token", {62'd0, token_cnt}, 64'd1);
        check("t1_busy", {63'd0, busy}, 64'd0);

        // All ports requesting from reset: order 0,1,2,3,0.
        do_reset();
        dec_rand_en = 1'b1;
        for (int p = 0; p < NP; p++) add_pkt(p, 2);
        add_pkt(0, 3);
        run_packets();
        add_pkt(2, 2);
        run_packets();
        dec_rand_en = 1'b0;

        // Token saturation blocks a new grant until a token is consumed.
        repeat (3) @(posedge clk_i);
        #1;
        do_reset();
        add_pkt(0, 1);
        add_pkt(1, 2);
        add_pkt(2, 3);
        run_packets();
        check("full_flag", {63'd0, token_full}, 64'd1);
        bus.port_req_i = 4'b0001;
        cfg = 0;
        repeat (8) begin
            @(posedge clk_i);
            #1;
            check("full_no_grant", {59'd0, bus.port_gnt_o, busy}, 64'd0);
        end
        dec_drv = 1'b1;
        @(posedge clk_i);
        #1;
        dec_drv = 1'b0;
        add_pkt(0, 1);
        run_packets();
        check("full_regrant_tok", {62'd0, token_cnt}, 64'd3);

        // Decrement coincident with the drain increment at count 2.
        dec_drv = 1'b1;
        @(posedge clk_i);
        #1;
        dec_drv = 1'b0;
        check("tok_before_coinc", {62'd0, token_cnt}, 64'd2);
        dec_on_recv = 1'b1;
        add_pkt(1, 2);
        run_packets();
        dec_on_recv = 1'b0;
        check("tok_after_coinc", {62'd0, token_cnt}, 64'd2);

        // Reset while the second word of a packet is on the bus.
        bus.port_req_i = 4'b1000;
        cfg = 3;
        cyc = 0;
        while (bus.port_gnt_o == '0 && cyc < 50) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check("rst_test_grant", {60'd0, bus.port_gnt_o}, 64'b1000);
        sb_data.push_back(8'hA1);
        sb_gnt.push_back(4'b1000);
        sb_chan.push_back(CW'(3));
        bus.port_vld_i = 4'b1000;
        bus.port_data_i[31:24] = 8'hA1;
        @(posedge clk_i);
        #1;
        bus.port_data_i[31:24] = 8'hA2;
        #1;
        rst_n_i = 1'b0;
        #1;
        check_zero_outs("rst_mid_load");
        clear_inputs();
        @(posedge clk_i);
        #1;
        rst_n_i   = 1'b1;
        model_ptr = 0;
        check("rst_sb_drained", 64'(sb_data.size()), 64'd0);
        add_pkt(2, 2);
        add_pkt(0, 2);
        run_packets();

        // Randomised traffic with random token consumption.
        dec_rand_en = 1'b1;
        repeat (10) begin
            for (int p = 0; p < NP; p++) begin
                repeat ($urandom_range(0, 2)) add_pkt(p, $urandom_range(1, 6));
            end
            run_packets();
        end
        dec_rand_en = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        check("sb_empty", 64'(sb_data.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
